// File: rtl/pkt_wordlist_gen.sv
// Word-list packet generator: builds header, header checksum, data and
// data checksum in hardware and pushes them byte-by-byte into a FIFO port.
module pkt_wordlist_gen #(
  parameter int unsigned MIN_LEN          = 1,
  parameter int unsigned MAX_LEN          = 16,
  parameter int unsigned N_WORDS_MSB      = 15,
  parameter int unsigned PKT_VERSION      = 2,
  parameter int unsigned PKT_TYPE         = 1,
  parameter logic [7:0]  CHAR_BASE        = 8'h61,
  parameter bit          DISABLE_CHECKSUM = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 start,
  input  logic [N_WORDS_MSB:0] n_words,
  input  logic [15:0]          pkt_id,
  output logic [7:0]           dout,
  output logic                 wr_en,
  input  logic                 full,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned NW    = N_WORDS_MSB + 1;
  localparam int unsigned RANGE = MAX_LEN - MIN_LEN + 1;
  localparam int unsigned LW    = 7;   // word lengths up to 64
  localparam int unsigned DLW   = 24;  // data_len field width

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_HDR, S_HCSUM, S_DATA, S_PAD, S_DCSUM, S_DONE
  } state_t;

  state_t         r_state;
  logic [NW-1:0]  r_nw;
  logic [NW-1:0]  r_wi;
  logic [15:0]    r_id;
  logic [DLW-1:0] r_dlen;
  logic [LW-1:0]  r_off;
  logic [LW-1:0]  r_j;
  logic [4:0]     r_kc;
  logic [4:0]     r_jc;
  logic           r_term;
  logic [3:0]     r_idx;
  logic [1:0]     r_bcnt;
  logic [23:0]    r_asm;
  logic [31:0]    r_sum;
  logic [7:0]     r_dout;
  logic           r_pend;
  logic           r_busy;
  logic           r_done;
  logic           r_err;

  logic           w_load;
  logic           w_acc;
  logic           w_last_word;
  logic [LW-1:0]  w_len;
  logic           w_has_term;
  logic [DLW-1:0] w_dlen_sum;
  logic [LW-1:0]  w_off_nxt;
  logic [4:0]     w_kc_nxt;
  logic [4:0]     w_jc_nxt;
  logic [31:0]    w_csum;
  logic [31:0]    w_asm_next;
  logic [7:0]     w_hbyte;
  logic [7:0]     w_csbyte;
  logic [7:0]     w_gbyte;

  // Output handshake: a pending byte is written whenever the FIFO has room
  assign wr_en  = r_pend & ~full;
  assign w_load = ~r_pend | ~full;
  assign dout   = r_dout;
  assign busy   = r_busy;
  assign done   = r_done;
  assign err    = r_err;

  // Word geometry and pattern counters
  assign w_last_word = (r_wi == r_nw - NW'(1));
  assign w_len       = LW'(MIN_LEN) + r_off;
  assign w_has_term  = (w_len < LW'(MAX_LEN));
  assign w_dlen_sum  = r_dlen + DLW'(w_len) + DLW'(w_has_term);
  assign w_off_nxt   = (r_off == LW'(RANGE - 1)) ? '0 : r_off + LW'(1);
  assign w_kc_nxt    = (r_kc == 5'd25) ? 5'd0 : r_kc + 5'd1;
  assign w_jc_nxt    = (r_jc == 5'd25) ? 5'd0 : r_jc + 5'd1;
  assign w_csum      = ~r_sum;
  assign w_asm_next  = {w_gbyte, r_asm};

  // Header byte selected by byte index
  always_comb begin
    w_hbyte = 8'h00;
    case (r_idx)
      4'd0:    w_hbyte = 8'(PKT_VERSION);
      4'd1:    w_hbyte = 8'(PKT_TYPE);
      4'd4:    w_hbyte = r_dlen[7:0];
      4'd5:    w_hbyte = r_dlen[15:8];
      4'd6:    w_hbyte = r_dlen[23:16];
      4'd8:    w_hbyte = r_id[7:0];
      4'd9:    w_hbyte = r_id[15:8];
      default: w_hbyte = 8'h00;
    endcase
  end

  // Checksum byte, little-endian
  always_comb begin
    w_csbyte = 8'h00;
    if (!DISABLE_CHECKSUM) begin
      case (r_idx[1:0])
        2'd0:    w_csbyte = w_csum[7:0];
        2'd1:    w_csbyte = w_csum[15:8];
        2'd2:    w_csbyte = w_csum[23:16];
        default: w_csbyte = w_csum[31:24];
      endcase
    end
  end

  // Section byte being generated and whether it feeds the checksum
  always_comb begin
    w_gbyte = 8'h00;
    w_acc   = 1'b0;
    case (r_state)
      S_HDR: begin
        w_gbyte = w_hbyte;
        w_acc   = w_load;
      end
      S_DATA: begin
        w_gbyte = r_term ? 8'h00 : CHAR_BASE + 8'(r_jc);
        w_acc   = w_load;
      end
      S_PAD:   w_acc = w_load;
      default: w_acc = 1'b0;
    endcase
  end

  // Packet FSM, byte generator and checksum accumulation
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_nw    <= '0;
      r_wi    <= '0;
      r_id    <= '0;
      r_dlen  <= '0;
      r_off   <= '0;
      r_j     <= '0;
      r_kc    <= '0;
      r_jc    <= '0;
      r_term  <= 1'b0;
      r_idx   <= '0;
      r_bcnt  <= '0;
      r_asm   <= '0;
      r_sum   <= '0;
      r_dout  <= '0;
      r_pend  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (wr_en) r_pend <= 1'b0;
      if (w_acc) begin
        r_asm  <= w_asm_next[31:8];
        r_bcnt <= r_bcnt + 2'd1;
        if (r_bcnt == 2'd3) r_sum <= r_sum + w_asm_next;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (n_words == '0) begin
              r_err <= 1'b1;
            end else begin
              r_nw    <= n_words;
              r_id    <= pkt_id;
              r_busy  <= 1'b1;
              r_wi    <= '0;
              r_off   <= '0;
              r_dlen  <= '0;
              r_state <= S_COUNT;
            end
          end
        end
        S_COUNT: begin
          r_dlen <= w_dlen_sum;
          r_wi   <= r_wi + NW'(1);
          r_off  <= w_off_nxt;
          if (w_last_word) begin
            r_dlen  <= (w_dlen_sum + DLW'(3)) & ~DLW'(3);
            r_wi    <= '0;
            r_off   <= '0;
            r_kc    <= '0;
            r_jc    <= '0;
            r_j     <= '0;
            r_term  <= 1'b0;
            r_idx   <= '0;
            r_state <= S_HDR;
          end
        end
        S_HDR: begin
          if (w_load) begin
            r_dout <= w_gbyte;
            r_pend <= 1'b1;
            r_idx  <= r_idx + 4'd1;
            if (r_idx == 4'd11) begin
              r_idx   <= '0;
              r_state <= S_HCSUM;
            end
          end
        end
        S_HCSUM: begin
          if (w_load) begin
            r_dout <= w_csbyte;
            r_pend <= 1'b1;
            r_idx  <= r_idx + 4'd1;
            if (r_idx == 4'd3) begin
              r_idx   <= '0;
              r_sum   <= '0;
              r_asm   <= '0;
              r_bcnt  <= '0;
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_load) begin
            r_dout <= w_gbyte;
            r_pend <= 1'b1;
            if (!r_term && (r_j != w_len - LW'(1))) begin
              r_j  <= r_j + LW'(1);
              r_jc <= w_jc_nxt;
            end else if (!r_term && w_has_term) begin
              r_term <= 1'b1;
            end else if (w_last_word) begin
              r_state <= (r_bcnt == 2'd3) ? S_DCSUM : S_PAD;
            end else begin
              r_wi   <= r_wi + NW'(1);
              r_off  <= w_off_nxt;
              r_kc   <= w_kc_nxt;
              r_jc   <= w_kc_nxt;
              r_j    <= '0;
              r_term <= 1'b0;
            end
          end
        end
        S_PAD: begin
          if (w_load) begin
            r_dout <= 8'h00;
            r_pend <= 1'b1;
            if (r_bcnt == 2'd3) r_state <= S_DCSUM;
          end
        end
        S_DCSUM: begin
          if (w_load) begin
            r_dout <= w_csbyte;
            r_pend <= 1'b1;
            r_idx  <= r_idx + 4'd1;
            if (r_idx == 4'd3) begin
              r_idx   <= '0;
              r_sum   <= '0;
              r_asm   <= '0;
              r_bcnt  <= '0;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (!r_pend || wr_en) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_wordlist_gen.sv
// Bench for pkt_wordlist_gen: two instances (checksums on / off) share
// stimulus; a scoreboard queue per instance holds the expected byte stream.
module tb_pkt_wordlist_gen;

  localparam int T_MIN = 1;
  localparam int T_MAX = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        start = 1'b0;
  logic        full = 1'b0;
  logic [15:0] n_words = '0;
  logic [15:0] pkt_id = '0;
  logic [7:0]  dout0, dout1;
  logic        wr_en0, wr_en1, busy0, busy1, done0, done1, err0, err1;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp0[$];
  logic [7:0]  exp1[$];
  int          wcount0 = 0;
  int          dcount0 = 0;
  int          dcount1 = 0;
  bit          rand_full = 1'b0;
  bit          started0 = 1'b0;
  logic        prev_full = 1'b0;
  logic [7:0]  prev_dout0 = '0;

  always #5 CLK = ~CLK;

  pkt_wordlist_gen #(.MIN_LEN(T_MIN), .MAX_LEN(T_MAX), .DISABLE_CHECKSUM(1'b0)) u_dut0 (
    .CLK(CLK), .RESET(RESET), .start(start), .n_words(n_words), .pkt_id(pkt_id),
    .dout(dout0), .wr_en(wr_en0), .full(full), .busy(busy0), .done(done0), .err(err0)
  );

  pkt_wordlist_gen #(.MIN_LEN(T_MIN), .MAX_LEN(T_MAX), .DISABLE_CHECKSUM(1'b1)) u_dut1 (
    .CLK(CLK), .RESET(RESET), .start(start), .n_words(n_words), .pkt_id(pkt_id),
    .dout(dout1), .wr_en(wr_en1), .full(full), .busy(busy1), .done(done1), .err(err1)
  );

  // Pops expected bytes on every observed write and checks stall behaviour
  task automatic monitor();
    logic [7:0] e;
    forever begin
      @(negedge CLK);
      if (prev_full && started0 && busy0 && exp0.size() > 0) begin
        checks++;
        if (dout0 !== prev_dout0) begin
          errors++;
          $display("FAIL dout_stable_on_stall: got %02h expected %02h", dout0, prev_dout0);
        end
      end
      if (wr_en0) begin
        wcount0++;
        started0 = 1'b1;
        checks++;
        if (full) begin
          errors++;
          $display("FAIL wr_en_while_full: got wr_en=1 with full=1 expected wr_en=0");
        end
        checks++;
        if (exp0.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write0: got byte %02h expected no write", dout0);
        end else begin
          e = exp0.pop_front();
          if (dout0 !== e) begin
            errors++;
            $display("FAIL byte0 (remaining %0d): got %02h expected %02h", exp0.size(), dout0, e);
          end
        end
      end
      if (wr_en1) begin
        checks++;
        if (exp1.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write1: got byte %02h expected no write", dout1);
        end else begin
          e = exp1.pop_front();
          if (dout1 !== e) begin
            errors++;
            $display("FAIL byte1_nocsum (remaining %0d): got %02h expected %02h", exp1.size(), dout1, e);
          end
        end
      end
      if (done0) begin
        dcount0++;
        started0 = 1'b0;
      end
      if (done1) dcount1++;
      prev_full  = full;
      prev_dout0 = dout0;
    end
  endtask

  // FIFO full generator, pseudo-random when enabled
  task automatic full_driver();
    forever begin
      @(posedge CLK);
      #1;
      full = rand_full ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  endtask

  // Reference packet built directly from the word-list definition
  task automatic push_model(input int n, input logic [15:0] id);
    logic [7:0]  d[$];
    logic [7:0]  hdr[12];
    logic [31:0] hs, ds;
    logic [23:0] dl;
    int          len;
    for (int k = 0; k < n; k++) begin
      len = T_MIN + (k % (T_MAX - T_MIN + 1));
      for (int j = 0; j < len; j++) d.push_back(8'(32'h61 + ((k + j) % 26)));
      if (len < T_MAX) d.push_back(8'h00);
    end
    while (d.size() % 4 != 0) d.push_back(8'h00);
    dl  = 24'(d.size());
    hdr = '{8'h02, 8'h01, 8'h00, 8'h00, dl[7:0], dl[15:8], dl[23:16], 8'h00,
            id[7:0], id[15:8], 8'h00, 8'h00};
    hs = '0;
    for (int i = 0; i < 12; i += 4) hs += {hdr[i+3], hdr[i+2], hdr[i+1], hdr[i]};
    hs = ~hs;
    ds = '0;
    for (int i = 0; i < d.size(); i += 4) ds += {d[i+3], d[i+2], d[i+1], d[i]};
    ds = ~ds;
    for (int i = 0; i < 12; i++) begin
      exp0.push_back(hdr[i]);
      exp1.push_back(hdr[i]);
    end
    for (int i = 0; i < 4; i++) begin
      exp0.push_back(hs[8*i +: 8]);
      exp1.push_back(8'h00);
    end
    for (int i = 0; i < d.size(); i++) begin
      exp0.push_back(d[i]);
      exp1.push_back(d[i]);
    end
    for (int i = 0; i < 4; i++) begin
      exp0.push_back(ds[8*i +: 8]);
      exp1.push_back(8'h00);
    end
  endtask

  // Known-answer stream for n_words=3, pkt_id=5
  task automatic push_literal_3w();
    logic [7:0] lit[32];
    lit = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00,
            8'h05, 8'h00, 8'h00, 8'h00, 8'hEC, 8'hFE, 8'hFF, 8'hFF,
            8'h61, 8'h00, 8'h62, 8'h63, 8'h00, 8'h63, 8'h64, 8'h65,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h9E, 8'h9C, 8'h39, 8'h37};
    for (int i = 0; i < 32; i++) begin
      exp0.push_back(lit[i]);
      exp1.push_back(((i >= 12 && i < 16) || i >= 28) ? 8'h00 : lit[i]);
    end
  endtask

  task automatic drive_start(input int n, input logic [15:0] id);
    @(posedge CLK);
    #1;
    start   = 1'b1;
    n_words = 16'(n);
    pkt_id  = id;
    @(posedge CLK);
    #1;
    start   = 1'b0;
    n_words = 16'($urandom);
    pkt_id  = 16'($urandom);
  endtask

  task automatic wait_done(input int budget, output bit seen);
    int base;
    base = dcount0;
    seen = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge CLK);
      #2;
      if (dcount0 != base) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({dout0, wr_en0, busy0, done0, err0} !== 12'h0) begin
      errors++;
      $display("FAIL reset_outputs0: got %03h expected 000", {dout0, wr_en0, busy0, done0, err0});
    end
    checks++;
    if ({dout1, wr_en1, busy1, done1, err1} !== 12'h0) begin
      errors++;
      $display("FAIL reset_outputs1: got %03h expected 000", {dout1, wr_en1, busy1, done1, err1});
    end
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    checks++;
    if ({dout0, wr_en0, busy0, done0, err0} !== 12'h0) begin
      errors++;
      $display("FAIL idle_after_reset: got %03h expected 000", {dout0, wr_en0, busy0, done0, err0});
    end
  endtask

  task automatic test_basic();
    bit seen;
    int base_w, base_d, lat;
    base_w = wcount0;
    base_d = dcount0;
    push_literal_3w();
    drive_start(3, 16'd5);
    lat = 0;
    for (int c = 0; c < 3 + 3; c++) begin
      @(negedge CLK);
      #1;
      if (wcount0 != base_w) begin
        lat = c + 1;
        break;
      end
    end
    checks++;
    if (lat == 0) begin
      errors++;
      $display("FAIL first_write_latency: got no write within %0d cycles expected <= %0d", 6, 6);
    end
    wait_done(400, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL basic_done_timeout: got no done expected done");
    end
    checks++;
    if (exp0.size() != 0 || exp1.size() != 0) begin
      errors++;
      $display("FAIL basic_bytes_left: got %0d/%0d unwritten expected 0/0", exp0.size(), exp1.size());
    end
    checks++;
    if (busy0 !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_after_done: got %b expected 0", busy0);
    end
    checks++;
    if (wcount0 - base_w != 32) begin
      errors++;
      $display("FAIL basic_byte_count: got %0d expected 32", wcount0 - base_w);
    end
    @(posedge CLK);
    #2;
    checks++;
    if (done0 !== 1'b0 || dcount0 != base_d + 1) begin
      errors++;
      $display("FAIL basic_done_pulse: got done=%b pulses=%0d expected 0 and 1", done0, dcount0 - base_d);
    end
  endtask

  task automatic test_wrap();
    bit seen;
    int base_w;
    base_w = wcount0;
    push_model(4, 16'h1234);
    drive_start(4, 16'h1234);
    wait_done(400, seen);
    checks++;
    if (!seen || exp0.size() != 0 || exp1.size() != 0) begin
      errors++;
      $display("FAIL wrap_packet: got done=%b left=%0d/%0d expected done=1 left=0/0", seen, exp0.size(), exp1.size());
    end
    checks++;
    if (wcount0 - base_w != 36) begin
      errors++;
      $display("FAIL wrap_byte_count: got %0d expected 36", wcount0 - base_w);
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    rand_full = 1'b1;
    push_literal_3w();
    drive_start(3, 16'd5);
    wait_done(2000, seen);
    checks++;
    if (!seen || exp0.size() != 0 || exp1.size() != 0) begin
      errors++;
      $display("FAIL bp_packet3: got done=%b left=%0d/%0d expected done=1 left=0/0", seen, exp0.size(), exp1.size());
    end
    push_model(9, 16'hBEEF);
    drive_start(9, 16'hBEEF);
    wait_done(4000, seen);
    checks++;
    if (!seen || exp0.size() != 0 || exp1.size() != 0) begin
      errors++;
      $display("FAIL bp_packet9: got done=%b left=%0d/%0d expected done=1 left=0/0", seen, exp0.size(), exp1.size());
    end
    rand_full = 1'b0;
    repeat (2) @(posedge CLK);
  endtask

  task automatic test_err();
    int base_w;
    base_w = wcount0;
    @(posedge CLK);
    #1;
    start   = 1'b1;
    n_words = 16'd0;
    pkt_id  = 16'h7777;
    @(posedge CLK);
    #1;
    start = 1'b0;
    checks++;
    if (err0 !== 1'b1 || err1 !== 1'b1) begin
      errors++;
      $display("FAIL err_pulse: got %b%b expected 11", err0, err1);
    end
    checks++;
    if (busy0 !== 1'b0) begin
      errors++;
      $display("FAIL err_busy: got %b expected 0", busy0);
    end
    @(posedge CLK);
    #1;
    checks++;
    if (err0 !== 1'b0) begin
      errors++;
      $display("FAIL err_one_cycle: got %b expected 0", err0);
    end
    repeat (5) @(posedge CLK);
    #1;
    checks++;
    if (wcount0 != base_w || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL err_no_write: got writes=%0d busy=%b expected 0 and 0", wcount0 - base_w, busy0);
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    int base_d;
    base_d = dcount0;
    push_model(5, 16'h0A0B);
    drive_start(5, 16'h0A0B);
    @(posedge CLK);
    #1;
    start   = 1'b1;
    n_words = 16'd7;
    pkt_id  = 16'hDEAD;
    @(posedge CLK);
    #1;
    start = 1'b0;
    wait_done(600, seen);
    checks++;
    if (!seen || exp0.size() != 0) begin
      errors++;
      $display("FAIL b2b_first: got done=%b left=%0d expected done=1 left=0", seen, exp0.size());
    end
    push_model(2, 16'h0102);
    drive_start(2, 16'h0102);
    wait_done(600, seen);
    checks++;
    if (!seen || exp0.size() != 0 || exp1.size() != 0) begin
      errors++;
      $display("FAIL b2b_second: got done=%b left=%0d/%0d expected done=1 left=0/0", seen, exp0.size(), exp1.size());
    end
    repeat (40) @(posedge CLK);
    #2;
    checks++;
    if (dcount0 != base_d + 2 || dcount1 != dcount0) begin
      errors++;
      $display("FAIL b2b_packet_count: got %0d/%0d expected %0d/%0d", dcount0 - base_d, dcount1, 2, dcount0);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    bit hit;
    int base_w;
    base_w = wcount0;
    push_model(5, 16'h5555);
    drive_start(5, 16'h5555);
    hit = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge CLK);
      if (wcount0 - base_w >= 10) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL midreset_reach10: got %0d writes expected 10", wcount0 - base_w);
    end
    #1;
    RESET = 1'b1;
    exp0.delete();
    exp1.delete();
    started0 = 1'b0;
    #1;
    checks++;
    if ({dout0, wr_en0, busy0, done0, err0} !== 12'h0 || {dout1, wr_en1, busy1} !== 10'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got %03h expected 000", {dout0, wr_en0, busy0, done0, err0});
    end
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    push_model(5, 16'h5555);
    drive_start(5, 16'h5555);
    wait_done(600, seen);
    checks++;
    if (!seen || exp0.size() != 0 || exp1.size() != 0) begin
      errors++;
      $display("FAIL midreset_repacket: got done=%b left=%0d/%0d expected done=1 left=0/0", seen, exp0.size(), exp1.size());
    end
  endtask

  initial begin
    fork
      monitor();
      full_driver();
    join_none
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_err();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
